octave_band_averager: RTL and testbench

Parametrised successor to the fixed 8-band FFT magnitude averager. It reduces one frame of streamed FFT magnitudes into `N_BANDS` octave bands (bins 1, 2–3, 4–7, …, N/2/2..N/2−1). Each band result is either the rounded average or the peak of the band. The block sits between the magnitude stage and the display/feature logic. It adds reset, per-frame mode select, sequence checking, and coherent double-buffered outputs.

---
 rtl/octave_avg_pkg.sv | 21 ++
 rtl/band_reduce.sv | 45 ++++
 rtl/octave_band_averager.sv | 120 ++++++++++++
 tb/tb_octave_band_averager.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/octave_avg_pkg.sv
// Shared types and helpers for the octave band averager.
package octave_avg_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SKIP  = 2'd2
  } state_t;

  localparam logic MODE_AVG  = 1'b0;
  localparam logic MODE_PEAK = 1'b1;

  function automatic int unsigned band_last(input int unsigned b);
    return (32'd1 << (b + 1)) - 32'd1;
  endfunction

  function automatic int acc_w(input int data_w, input int n_bands);
    return data_w + n_bands - 1;
  endfunction

endpackage

// File: rtl/band_reduce.sv
// Per-sample band reduction: next accumulator (sum or max) and the band result
// that would be produced if this sample closes the band.
module band_reduce import octave_avg_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int N_BANDS = 8,
  parameter int BAND_W  = 3,
  parameter int ACC_W   = acc_w(DATA_W, N_BANDS)
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] mag,
  input  logic              restart,
  input  logic              mode,
  input  logic [BAND_W-1:0] band,
  output logic [ACC_W-1:0]  acc_next,
  output logic [DATA_W-1:0] result
);

  // Band b holds 2^b bins, so the sum is divided by a shift of b with half-up rounding.
  function automatic logic [DATA_W-1:0] round_sat(input logic [ACC_W-1:0] sum,
                                                  input logic [BAND_W-1:0] sh);
    logic [ACC_W:0] rnd;
    logic [ACC_W:0] total;
    rnd = '0;
    if (sh != '0) rnd = (ACC_W+1)'(1) << (sh - BAND_W'(1));
    total = ({1'b0, sum} + rnd) >> sh;
    if (total > (ACC_W+1)'({DATA_W{1'b1}})) return '1;
    return total[DATA_W-1:0];
  endfunction

  logic [ACC_W-1:0] mag_ext;

  assign mag_ext = ACC_W'(mag);

  always_comb begin
    acc_next = acc + mag_ext;
    if (restart) begin
      acc_next = mag_ext;
    end else if (mode == MODE_PEAK) begin
      acc_next = (mag_ext > acc) ? mag_ext : acc;
    end
  end

  assign result = (mode == MODE_PEAK) ? acc_next[DATA_W-1:0] : round_sat(acc_next, band);

endmodule

// File: rtl/octave_band_averager.sv
// Reduces one frame of streamed FFT magnitudes into octave bands (average or peak)
// with sequence checking and atomically published, double-buffered results.
module octave_band_averager import octave_avg_pkg::*; #(
  parameter  int DATA_W   = 32,
  parameter  int N_POINTS = 512,
  localparam int IDX_W    = $clog2(N_POINTS),
  localparam int N_BANDS  = IDX_W - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [IDX_W-1:0]          in_index,
  input  logic [DATA_W-1:0]         in_mag,
  input  logic                      mode,
  output logic [N_BANDS*DATA_W-1:0] band_data,
  output logic                      out_valid,
  output logic                      frame_done,
  output logic                      seq_err
);

  localparam int               BAND_W    = $clog2(N_BANDS);
  localparam int               ACC_W     = acc_w(DATA_W, N_BANDS);
  localparam logic [IDX_W-1:0] HALF_LAST = IDX_W'(band_last(N_BANDS - 1));

  state_t              state;
  logic                mode_r;
  logic [IDX_W-1:0]    exp_idx;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic [DATA_W-1:0]   res;
  logic [DATA_W-1:0]   stage [N_BANDS];
  logic [BAND_W-1:0]   band;
  logic                restart;
  logic                closing;
  logic                in_seq;

  // Band number is the position of the highest set bit of the bin index.
  always_comb begin
    band = '0;
    for (int i = 0; i < N_BANDS; i++) begin
      if (in_index[i]) band = BAND_W'(i);
    end
  end

  assign restart = (in_index & (in_index - IDX_W'(1))) == '0;
  assign closing = (in_index & (in_index + IDX_W'(1))) == '0;
  assign in_seq  = in_valid && (state == S_ACCUM) && (in_index == exp_idx);

  band_reduce #(
    .DATA_W (DATA_W),
    .N_BANDS(N_BANDS),
    .BAND_W (BAND_W),
    .ACC_W  (ACC_W)
  ) u_reduce (
    .acc     (acc),
    .mag     (in_mag),
    .restart (restart),
    .mode    (mode_r),
    .band    (band),
    .acc_next(acc_next),
    .result  (res)
  );

  always_ff @(posedge clk) begin
    if (in_seq) begin
      acc <= acc_next;
      if (closing) stage[band] <= res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      mode_r     <= MODE_AVG;
      exp_idx    <= '0;
      band_data  <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      if (in_valid) begin
        case (state)
          S_IDLE, S_SKIP: begin
            if (in_index == '0) begin
              state   <= S_ACCUM;
              mode_r  <= mode;
              exp_idx <= IDX_W'(1);
            end
          end
          S_ACCUM: begin
            if (in_index == exp_idx) begin
              exp_idx <= exp_idx + IDX_W'(1);
              if (in_index == HALF_LAST) begin
                // The last band's result is still in flight, so take it directly.
                state      <= S_SKIP;
                frame_done <= 1'b1;
                out_valid  <= 1'b1;
                for (int b = 0; b < N_BANDS; b++) begin
                  band_data[b*DATA_W +: DATA_W] <= (b == N_BANDS - 1) ? res : stage[b];
                end
              end
            end else begin
              seq_err <= 1'b1;
              if (in_index == '0) begin
                mode_r  <= mode;
                exp_idx <= IDX_W'(1);
              end else begin
                state <= S_IDLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_octave_band_averager.sv
// Bench for octave_band_averager at N_POINTS=16, DATA_W=8 (three bands).
module tb_octave_band_averager;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_index;
  logic [7:0]  in_mag;
  logic        mode;
  logic [23:0] band_data;
  logic        out_valid;
  logic        frame_done;
  logic        seq_err;

  typedef struct {
    logic         mode;
    logic [127:0] mags;
    logic [23:0]  exp;
  } vec_t;

  vec_t        vecs [5];
  logic [23:0] sb [$];
  logic [23:0] last_pub;
  int          checks = 0;
  int          errors = 0;
  int          seq_seen = 0;
  int          seq_exp = 0;
  bit          gaps_en = 1'b1;

  octave_band_averager #(.DATA_W(8), .N_POINTS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_index  (in_index),
    .in_mag    (in_mag),
    .mode      (mode),
    .band_data (band_data),
    .out_valid (out_valid),
    .frame_done(frame_done),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) begin
        if (seq_err) check("frame_done_seq_err_overlap", 32'(seq_err), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          last_pub = sb.pop_front();
          check("band_data", 32'(band_data), 32'(last_pub));
          check("out_valid_on_publish", 32'(out_valid), 32'd1);
        end
      end
      if (seq_err) seq_seen++;
    end
  end

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_index = 4'($urandom);
    in_mag   = 8'($urandom);
    mode     = 1'($urandom);
  endtask

  task automatic drive(input int idx, input logic [7:0] mg, input logic m);
    if (gaps_en && $urandom_range(0, 3) == 0) idle();
    @(negedge clk);
    in_valid = 1'b1;
    in_index = 4'(idx);
    in_mag   = mg;
    mode     = m;
  endtask

  task automatic send_frame(input logic m0, input logic mr, input logic [127:0] mg,
                            input int first_bin, input int last_bin,
                            input logic [23:0] ex, input bit push);
    for (int i = first_bin; i <= last_bin; i++) begin
      drive(i, mg[i*8 +: 8], (i == 0) ? m0 : mr);
      if (i == 7 && push) sb.push_back(ex);
    end
  endtask

  initial begin
    logic [127:0] m;

    for (int i = 0; i < 16; i++) m[i*8 +: 8] = 8'(i);
    vecs[0] = '{mode: 1'b0, mags: m, exp: 24'h060301};
    vecs[1] = '{mode: 1'b1, mags: m, exp: 24'h070301};
    for (int i = 0; i < 16; i++) m[i*8 +: 8] = 8'd255;
    vecs[2] = '{mode: 1'b0, mags: m, exp: 24'hFFFFFF};
    for (int i = 0; i < 16; i++) m[i*8 +: 8] = 8'hEE;
    m[1*8 +: 8] = 8'd10;  m[2*8 +: 8] = 8'd254; m[3*8 +: 8] = 8'd255;
    m[4*8 +: 8] = 8'd100; m[5*8 +: 8] = 8'd101; m[6*8 +: 8] = 8'd102; m[7*8 +: 8] = 8'd103;
    vecs[3] = '{mode: 1'b0, mags: m, exp: 24'h66FF0A};
    m[1*8 +: 8] = 8'd9;   m[2*8 +: 8] = 8'd200; m[3*8 +: 8] = 8'd3;
    m[4*8 +: 8] = 8'd50;  m[5*8 +: 8] = 8'd250; m[6*8 +: 8] = 8'd7;   m[7*8 +: 8] = 8'd1;
    vecs[4] = '{mode: 1'b1, mags: m, exp: 24'hFAC809};

    rst = 1'b1; in_valid = 1'b0; in_index = '0; in_mag = '0; mode = 1'b0;
    last_pub = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_band_data", 32'(band_data), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_seq_err", 32'(seq_err), 32'd0);

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].mode, vecs[v].mode, vecs[v].mags, 0, 15, vecs[v].exp, 1'b1);
      idle();
    end

    // Mode toggled after index 0 must not affect the frame.
    send_frame(1'b0, 1'b1, vecs[0].mags, 0, 15, 24'h060301, 1'b1);
    idle(); idle();

    // Skipped index: abort to IDLE, published data untouched.
    drive(0, 8'd0, 1'b1); drive(1, 8'd200, 1'b1); drive(2, 8'd200, 1'b1); drive(4, 8'd200, 1'b1);
    idle();
    check("seq_err_skip", 32'(seq_err), 32'd1);
    seq_exp++;
    idle(); idle();
    check("band_data_after_abort", 32'(band_data), 32'(last_pub));
    send_frame(1'b0, 1'b0, vecs[0].mags, 0, 15, 24'h060301, 1'b1);
    idle();

    // Early index 0 restarts immediately; the partial frame must be discarded.
    for (int i = 0; i <= 5; i++) drive(i, 8'd255, 1'b1);
    drive(0, 8'hEE, 1'b0);
    idle();
    check("seq_err_restart", 32'(seq_err), 32'd1);
    seq_exp++;
    send_frame(1'b0, 1'b0, vecs[3].mags, 1, 15, vecs[3].exp, 1'b1);
    idle();

    // Index 0 arrives in the publication cycle of the previous frame.
    gaps_en = 1'b0;
    send_frame(1'b1, 1'b1, vecs[1].mags, 0, 7, vecs[1].exp, 1'b1);
    send_frame(1'b0, 1'b0, vecs[2].mags, 0, 15, vecs[2].exp, 1'b1);
    gaps_en = 1'b1;
    idle(); idle();

    // Asynchronous reset in the middle of a frame.
    send_frame(1'b0, 1'b0, vecs[0].mags, 0, 5, 24'h0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_band_data", 32'(band_data), 32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    last_pub = '0;
    @(negedge clk);
    rst = 1'b0;
    send_frame(1'b0, 1'b0, vecs[0].mags, 6, 15, 24'h0, 1'b0);
    idle(); idle();
    check("no_publish_without_index0", 32'(out_valid), 32'd0);
    check("band_data_still_zero", 32'(band_data), 32'd0);
    send_frame(1'b0, 1'b0, vecs[3].mags, 0, 15, vecs[3].exp, 1'b1);
    idle(); idle();
    check("out_valid_after_reset_frame", 32'(out_valid), 32'd1);

    repeat (5) idle();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("seq_err_count", 32'(seq_seen), 32'(seq_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
